// File: rtl/scanline_mixer.sv
// Scanline darkening and sync alignment stage behind the scandoubler.
// Odd output lines are dimmed, vsync is re-timed to line starts, and all outputs are registered.

module scanline_dim #(
  parameter int DW = 6
) (
  input  logic [1:0]    mode,
  input  logic          en,
  input  logic [DW-1:0] c,
  output logic [DW-1:0] y
);
  always_comb begin
    y = c;
    if (en) begin
      case (mode)
        2'd1:    y = c - (c >> 2);
        2'd2:    y = c >> 1;
        2'd3:    y = c >> 2;
        default: y = c;
      endcase
    end
  end
endmodule

module scanline_mixer #(
  parameter int DW = 6
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          bypass,
  input  logic [1:0]    scanlines,
  input  logic          hs_in,
  input  logic          vs_in,
  input  logic [DW-1:0] r_in,
  input  logic [DW-1:0] g_in,
  input  logic [DW-1:0] b_in,
  output logic          hs_out,
  output logic          vs_out,
  output logic          cs_out,
  output logic [DW-1:0] r_out,
  output logic [DW-1:0] g_out,
  output logic [DW-1:0] b_out
);
  logic hs_d_q, vs_d_q;
  logic odd_line_q, odd_line_d;
  logic [1:0] mode_l_q, mode_l_d;
  logic vs_hold_q, vs_hold_d;
  logic vs_line_q, vs_line_d;
  logic hs_out_q, hs_out_d, vs_out_q, vs_out_d, cs_out_q, cs_out_d;
  logic [2:0][DW-1:0] rgb_in, rgb_dim, rgb_out_q;
  logic hs_fall, vs_edge, dark_en;

  assign hs_fall = hs_d_q & ~hs_in;
  assign vs_edge = vs_d_q ^ vs_in;
  assign rgb_in  = {r_in, g_in, b_in};

  always_comb begin
    odd_line_d = odd_line_q;
    mode_l_d   = mode_l_q;
    vs_hold_d  = vs_hold_q;
    vs_line_d  = vs_line_q;
    if (hs_fall) begin
      odd_line_d = ~odd_line_q;
      mode_l_d   = scanlines;
      vs_hold_d  = vs_in;
      vs_line_d  = vs_hold_q;
    end
    // A frame boundary always restarts parity, even on a coincident line start.
    if (vs_edge) odd_line_d = 1'b0;
  end

  // The pixel that arrives with the hsync fall already belongs to the new line.
  assign dark_en = odd_line_d & (mode_l_d != 2'd0) & ~bypass;

  for (genvar ch = 0; ch < 3; ch++) begin : g_ch
    scanline_dim #(.DW(DW)) u_dim (
      .mode (mode_l_d),
      .en   (dark_en),
      .c    (rgb_in[ch]),
      .y    (rgb_dim[ch])
    );
  end

  always_comb begin
    hs_out_d = hs_in;
    vs_out_d = bypass ? vs_in : vs_line_d;
    cs_out_d = ~(hs_out_d ^ vs_out_d);
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      hs_d_q     <= 1'b0;
      vs_d_q     <= 1'b0;
      odd_line_q <= 1'b0;
      mode_l_q   <= 2'd0;
      vs_hold_q  <= 1'b0;
      vs_line_q  <= 1'b0;
      hs_out_q   <= 1'b0;
      vs_out_q   <= 1'b0;
      cs_out_q   <= 1'b0;
      rgb_out_q  <= '0;
    end else begin
      hs_d_q     <= hs_in;
      vs_d_q     <= vs_in;
      odd_line_q <= odd_line_d;
      mode_l_q   <= mode_l_d;
      vs_hold_q  <= vs_hold_d;
      vs_line_q  <= vs_line_d;
      hs_out_q   <= hs_out_d;
      vs_out_q   <= vs_out_d;
      cs_out_q   <= cs_out_d;
      rgb_out_q  <= rgb_dim;
    end
  end

  assign hs_out = hs_out_q;
  assign vs_out = vs_out_q;
  assign cs_out = cs_out_q;
  assign r_out  = rgb_out_q[2];
  assign g_out  = rgb_out_q[1];
  assign b_out  = rgb_out_q[0];
endmodule

// File: tb/tb_scanline_mixer.sv
// Bench for scanline_mixer: per-cycle reference model plus table and directed line sequences.

module tb_scanline_mixer;
  localparam int DW = 6;

  logic clk_sys = 1'b0;
  logic reset_n, bypass, hs_in, vs_in;
  logic [1:0] scanlines;
  logic [DW-1:0] r_in, g_in, b_in;
  logic hs_out, vs_out, cs_out;
  logic [DW-1:0] r_out, g_out, b_out;

  always #5 clk_sys = ~clk_sys;

  scanline_mixer #(.DW(DW)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .bypass(bypass), .scanlines(scanlines),
    .hs_in(hs_in), .vs_in(vs_in), .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .hs_out(hs_out), .vs_out(vs_out), .cs_out(cs_out),
    .r_out(r_out), .g_out(g_out), .b_out(b_out)
  );

  int tests = 0, fails = 0;

  // Reference model: line counter since last frame edge, vsync samples taken at line starts.
  logic m_hs_prev, m_vs_prev;
  int   m_lines;
  int   m_mode;
  logic vq[$];
  logic e_hs, e_vs, e_cs;
  int   e_r, e_g, e_b;

  function automatic int dim(input int c, input int mode);
    case (mode)
      1:       return (3 * c + 3) / 4;
      2:       return c / 2;
      3:       return c / 4;
      default: return c;
    endcase
  endfunction

  task automatic model();
    bit fall, vedge, dark;
    if (!reset_n) begin
      m_hs_prev = 0; m_vs_prev = 0; m_lines = 0; m_mode = 0;
      vq = '{1'b0, 1'b0};
      e_hs = 0; e_vs = 0; e_cs = 0; e_r = 0; e_g = 0; e_b = 0;
      return;
    end
    fall  = m_hs_prev && !hs_in;
    vedge = m_vs_prev != vs_in;
    if (fall) begin
      m_mode = scanlines;
      vq.push_back(vs_in);
      void'(vq.pop_front());
    end
    if (vedge) m_lines = 0;
    else if (fall) m_lines++;
    dark = (m_lines % 2 == 1) && m_mode != 0 && !bypass;
    e_hs = hs_in;
    e_vs = bypass ? vs_in : vq[0];
    e_cs = !(e_hs ^ e_vs);
    e_r  = dark ? dim(r_in, m_mode) : r_in;
    e_g  = dark ? dim(g_in, m_mode) : g_in;
    e_b  = dark ? dim(b_in, m_mode) : b_in;
    m_hs_prev = hs_in;
    m_vs_prev = vs_in;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_sys);
    model();
    #1;
    chk("model", {hs_out, vs_out, cs_out, r_out, g_out, b_out},
        {e_hs, e_vs, e_cs, e_r[DW-1:0], e_g[DW-1:0], e_b[DW-1:0]});
  endtask

  task automatic set_rgb(input logic [DW-1:0] c);
    r_in = c; g_in = c; b_in = c;
  endtask

  // One line: hs high for hi cycles, then lo active cycles; returns r_out mid-line.
  task automatic run_line(input int hi, input int lo, input logic [DW-1:0] c,
                          output logic [DW-1:0] mid_r);
    hs_in = 1;
    repeat (hi) step();
    hs_in = 0;
    set_rgb(c);
    mid_r = '0;
    for (int i = 0; i < lo; i++) begin
      step();
      if (i == lo / 2) mid_r = r_out;
    end
  endtask

  typedef struct {
    logic [1:0]    mode;
    logic [DW-1:0] c;
    logic [DW-1:0] dark;
  } vec_t;
  vec_t tbl[6];

  initial begin
    logic [DW-1:0] mr;
    int hcnt;

    tbl[0] = '{2'd2, 6'h3F, 6'h1F};
    tbl[1] = '{2'd1, 6'h3F, 6'h30};
    tbl[2] = '{2'd3, 6'h3F, 6'h0F};
    tbl[3] = '{2'd1, 6'h15, 6'h10};
    tbl[4] = '{2'd3, 6'h15, 6'h05};
    tbl[5] = '{2'd0, 6'h2A, 6'h2A};

    // Reset with busy inputs
    reset_n = 0; bypass = 0; scanlines = 2; hs_in = 1; vs_in = 1; set_rgb(6'h3F);
    repeat (3) step();
    chk("reset_outs", {hs_out, vs_out, cs_out, r_out, g_out, b_out}, '0);
    reset_n = 1;
    step();
    chk("post_reset_track", {hs_out, r_out}, {1'b1, 6'h3F});
    vs_in = 0;
    step();

    // Table: clear parity with a frame edge, then four lines alternate odd/even.
    foreach (tbl[v]) begin
      scanlines = tbl[v].mode;
      vs_in = ~vs_in;
      step();
      for (int k = 1; k <= 4; k++) begin
        run_line(2, 8, tbl[v].c, mr);
        chk($sformatf("tbl%0d_line%0d", v, k), mr, (k % 2 == 1) ? tbl[v].dark : tbl[v].c);
      end
    end

    // vsync rising mid-line N shows up after the start of line N+2.
    scanlines = 0; vs_in = 0;
    run_line(2, 6, 6'h11, mr);
    run_line(2, 6, 6'h11, mr);
    hs_in = 1; repeat (2) step();
    hs_in = 0; repeat (3) step();
    vs_in = 1; repeat (3) step();
    hs_in = 1; repeat (2) step();
    hs_in = 0; step();
    chk("vs_line_n1", vs_out, 1'b0);
    repeat (4) step();
    hs_in = 1; repeat (2) step();
    chk("vs_before_n2", vs_out, 1'b0);
    hs_in = 0; step();
    chk("vs_line_n2", vs_out, 1'b1);
    repeat (4) step();

    // Coincident frame edge and line start: that line is even.
    scanlines = 2;
    hs_in = 1; repeat (2) step();
    hs_in = 0; vs_in = ~vs_in; set_rgb(6'h3F);
    repeat (3) step();
    chk("sync_even", r_out, 6'h3F);
    run_line(2, 6, 6'h3F, mr);
    chk("sync_next_odd", mr, 6'h1F);

    // Mid-line mode change holds until next line.
    hs_in = 0; vs_in = ~vs_in; step();
    scanlines = 2;
    hs_in = 1; repeat (2) step();
    hs_in = 0; set_rgb(6'h3F); repeat (2) step();
    chk("mode_before", r_out, 6'h1F);
    scanlines = 3; repeat (2) step();
    chk("mode_hold", r_out, 6'h1F);
    run_line(2, 6, 6'h3F, mr);
    chk("mode_even", mr, 6'h3F);
    run_line(2, 6, 6'h3F, mr);
    chk("mode_new", mr, 6'h0F);

    // Bypass: no dimming, vsync one clock; parity keeps running.
    bypass = 1; scanlines = 3;
    vs_in = ~vs_in; step();
    chk("byp_vs", vs_out, vs_in);
    run_line(2, 6, 6'h3F, mr);
    chk("byp_odd", mr, 6'h3F);
    run_line(2, 6, 6'h3F, mr);
    chk("byp_even", mr, 6'h3F);
    bypass = 0;
    run_line(2, 6, 6'h3F, mr);
    chk("byp_resume_odd", mr, 6'h0F);
    run_line(2, 6, 6'h3F, mr);
    chk("byp_resume_even", mr, 6'h3F);

    // Reset mid-line: outputs drop at once.
    set_rgb(6'h2A); step();
    #2 reset_n = 0; #1;
    chk("async_reset", {hs_out, vs_out, cs_out, r_out, g_out, b_out}, '0);
    step();
    reset_n = 1; vs_in = 0; hs_in = 1; scanlines = 2;
    step();
    run_line(2, 6, 6'h3F, mr);
    chk("reset_first_odd", mr, 6'h1F);

    // Randomized traffic against the model.
    hcnt = 0;
    for (int n = 0; n < 4000; n++) begin
      if (hcnt == 0) begin
        hs_in = ~hs_in;
        hcnt = hs_in ? $urandom_range(1, 3) : $urandom_range(3, 12);
      end
      hcnt--;
      r_in = DW'($urandom); g_in = DW'($urandom); b_in = DW'($urandom);
      if ($urandom_range(0, 15) == 0) scanlines = 2'($urandom);
      if ($urandom_range(0, 40) == 0) vs_in = ~vs_in;
      if ($urandom_range(0, 150) == 0) bypass = ~bypass;
      reset_n = ($urandom_range(0, 400) != 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
